// File: rtl/alu_arbiter_microprocessor.sv
// Round-robin front end for the shared registered ALU: two requesters, one op in flight,
// illegal opcodes answered directly with an error response.
module alu_arbiter_microprocessor #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int FLAG_W = 4
) (
  input  logic              alu_clk,
  input  logic              alu_rst,
  input  logic              req0_valid,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rslt,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  input  logic [DATA_W-1:0] alu_rslt,
  input  logic [FLAG_W-1:0] alu_checks,
  output logic              busy
);
  // state   | meaning
  // IDLE    | nothing in flight, ALU driven with no-op, accepting
  // ISSUE   | latched op on the ALU inputs, ALU computes on the closing edge
  // CAPTURE | ALU result valid, captured on the closing edge, accepting
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;

  localparam logic [CTRL_W-1:0] ALU_NOP   = '1;
  localparam logic [FLAG_W-1:0] ERR_FLAGS = FLAG_W'(4'b0100);

  state_t            state;
  logic              ptr;
  logic              op_owner;
  logic              hold_full;
  logic              hold_owner;
  logic [DATA_W-1:0] hold_rslt;
  logic [FLAG_W-1:0] hold_flags;

  logic              accept_en, gnt0, gnt1, acc, acc_owner, acc_illegal, acc_legal;
  logic [CTRL_W-1:0] acc_ctrl;
  logic [DATA_W-1:0] acc_a, acc_b;

  // ptr=1 means req1 is favoured when both requesters are valid
  always_comb begin
    accept_en   = !alu_rst && (state != ISSUE) && !hold_full;
    gnt1        = req1_valid && (!req0_valid || ptr);
    gnt0        = req0_valid && !gnt1;
    req0_ready  = accept_en && gnt0;
    req1_ready  = accept_en && gnt1;
    acc         = req0_ready || req1_ready;
    acc_owner   = gnt1;
    acc_ctrl    = gnt1 ? req1_ctrl : req0_ctrl;
    acc_a       = gnt1 ? req1_a : req0_a;
    acc_b       = gnt1 ? req1_b : req0_b;
    acc_illegal = acc && (acc_ctrl[CTRL_W-1:1] == {(CTRL_W-1){1'b1}});
    acc_legal   = acc && !acc_illegal;
  end

  always_ff @(posedge alu_clk) begin
    if (alu_rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      op_owner   <= 1'b0;
      hold_full  <= 1'b0;
      hold_owner <= 1'b0;
      hold_rslt  <= '0;
      hold_flags <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rslt   <= '0;
      rsp_flags  <= '0;
      alu_ctrl   <= ALU_NOP;
      alu_in_1   <= '0;
      alu_in_2   <= '0;
      busy       <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_err    <= 1'b0;
      if (acc) ptr <= ~acc_owner;

      unique case (state)
        IDLE, CAPTURE: begin
          if (acc_legal) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            op_owner <= acc_owner;
            alu_ctrl <= acc_ctrl;
            alu_in_1 <= acc_a;
            alu_in_2 <= acc_b;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          state    <= CAPTURE;
          busy     <= 1'b1;
          alu_ctrl <= ALU_NOP;
          alu_in_1 <= '0;
          alu_in_2 <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // An error response pre-empts the bus; the concurrent ALU result waits one cycle in hold
      if (acc_illegal) begin
        rsp0_valid <= ~acc_owner;
        rsp1_valid <= acc_owner;
        rsp_err    <= 1'b1;
        rsp_rslt   <= '0;
        rsp_flags  <= ERR_FLAGS;
        if (state == CAPTURE) begin
          hold_full  <= 1'b1;
          hold_owner <= op_owner;
          hold_rslt  <= alu_rslt;
          hold_flags <= alu_checks;
        end
      end else if (state == CAPTURE) begin
        rsp0_valid <= ~op_owner;
        rsp1_valid <= op_owner;
        rsp_rslt   <= alu_rslt;
        rsp_flags  <= alu_checks;
      end else if (hold_full) begin
        hold_full  <= 1'b0;
        rsp0_valid <= ~hold_owner;
        rsp1_valid <= hold_owner;
        rsp_rslt   <= hold_rslt;
        rsp_flags  <= hold_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter_microprocessor.sv
// Bench for alu_arbiter_microprocessor: registered ALU stub, transaction-level model
// compared every cycle, plus directed literal checks.
module tb_alu_arbiter_microprocessor;
  logic        alu_clk = 1'b0;
  logic        alu_rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy;
  logic [31:0] rsp_rslt, alu_in_1, alu_in_2, alu_rslt;
  logic [3:0]  rsp_flags, alu_ctrl, alu_checks;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  alu_arbiter_microprocessor #(.DATA_W(32), .CTRL_W(4), .FLAG_W(4)) dut (
    .alu_clk(alu_clk), .alu_rst(alu_rst),
    .req0_valid(req0_valid), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rslt(rsp_rslt), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .alu_ctrl(alu_ctrl), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_rslt(alu_rslt), .alu_checks(alu_checks), .busy(busy)
  );

  always #5 alu_clk = ~alu_clk;

  // ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others give 0. Returns {V,Z,C,N,result}.
  function automatic logic [35:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic v, cy;
    w = '0; r = '0; v = 1'b0; cy = 1'b0;
    case (c)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; cy = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = '0;
    endcase
    return {v, (r == 32'd0), cy, r[31], r};
  endfunction

  always @(posedge alu_clk) {alu_checks, alu_rslt} <= alu_fn(alu_ctrl, alu_in_1, alu_in_2);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (!chk_en) return;
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int cyc;
    bit owner;
    bit err;
    logic [31:0] r;
    logic [3:0] f;
  } ev_t;

  ev_t exp_q[$];
  ev_t rsp_log[$];
  ev_t grant_log[$];

  // Model: an op accepted at cycle t answers at t+3 and blocks acceptance until t+2;
  // an illegal op answers at t+1 and pushes any result due at t+1 to t+2.
  int          cyc = 0;
  int          next_ok = 0;
  bit          m_ptr = 0;
  bit          e0, e1, fnd, w;
  ev_t         fe;
  logic [3:0]  mc;
  logic [31:0] ma, mb;
  logic [35:0] fr;
  bit          busy_exp [1024];
  bit          iss_v [1024];
  logic [3:0]  iss_c [1024];
  logic [31:0] iss_a [1024];
  logic [31:0] iss_b [1024];

  always @(negedge alu_clk) begin
    e0 = 0; e1 = 0;
    if (!alu_rst && cyc >= next_ok) begin
      if (req0_valid && req1_valid) begin
        if (m_ptr) e1 = 1; else e0 = 1;
      end else if (req0_valid) e0 = 1;
      else if (req1_valid) e1 = 1;
    end
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    if (chk_en && (req0_ready || req1_ready)) grant_log.push_back('{cyc, req1_ready, 1'b0, 32'd0, 4'd0});

    fnd = 0;
    fe = '{0, 1'b0, 1'b0, 32'd0, 4'd0};
    foreach (exp_q[i]) if (exp_q[i].cyc == cyc) begin fnd = 1; fe = exp_q[i]; end
    chk("rsp0_valid", rsp0_valid, fnd && !fe.owner);
    chk("rsp1_valid", rsp1_valid, fnd && fe.owner);
    if (fnd) begin
      chk("rsp_err", rsp_err, fe.err);
      chk("rsp_rslt", rsp_rslt, fe.r);
      chk("rsp_flags", rsp_flags, fe.f);
    end
    if (chk_en && (rsp0_valid || rsp1_valid)) rsp_log.push_back('{cyc, rsp1_valid, rsp_err, rsp_rslt, rsp_flags});
    chk("busy", busy, busy_exp[cyc]);
    chk("alu_ctrl", alu_ctrl, iss_v[cyc] ? iss_c[cyc] : 4'hF);
    chk("alu_in_1", alu_in_1, iss_v[cyc] ? iss_a[cyc] : 32'd0);
    chk("alu_in_2", alu_in_2, iss_v[cyc] ? iss_b[cyc] : 32'd0);

    if (alu_rst) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].cyc > cyc) exp_q.delete(i);
      for (int k = 1; k <= 3; k++) begin busy_exp[cyc + k] = 0; iss_v[cyc + k] = 0; end
      next_ok = cyc + 1;
      m_ptr = 0;
    end else if (e0 || e1) begin
      w  = e1;
      mc = w ? req1_ctrl : req0_ctrl;
      ma = w ? req1_a : req0_a;
      mb = w ? req1_b : req0_b;
      m_ptr = !w;
      if (mc == 4'hE || mc == 4'hF) begin
        exp_q.push_back('{cyc + 1, w, 1'b1, 32'd0, 4'b0100});
        next_ok = cyc + 1;
        foreach (exp_q[i]) if (exp_q[i].cyc == cyc + 1 && !exp_q[i].err) begin
          exp_q[i].cyc = cyc + 2;
          next_ok = cyc + 2;
        end
      end else begin
        fr = alu_fn(mc, ma, mb);
        exp_q.push_back('{cyc + 3, w, 1'b0, fr[31:0], fr[35:32]});
        next_ok = cyc + 2;
        busy_exp[cyc + 1] = 1; busy_exp[cyc + 2] = 1;
        iss_v[cyc + 1] = 1; iss_c[cyc + 1] = mc; iss_a[cyc + 1] = ma; iss_b[cyc + 1] = mb;
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].cyc <= cyc) exp_q.delete(i);
    cyc++;
  end

  task automatic drive(input bit wh, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 0;
    if (wh) begin req1_ctrl = c; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_ctrl = c; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge alu_clk);
      if (wh ? req1_ready : req0_ready) got = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL drive_timeout requester=%0d actual=no_ready required=ready", wh);
    end
    @(posedge alu_clk); #1;
    if (wh) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic stream(input bit wh, input int n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < n; i++) drive(wh, c, a, b);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge alu_clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge alu_clk); #1 alu_rst = 1'b1;
    @(posedge alu_clk); #1 alu_rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge alu_clk);
    #1 chk_en = 1;
    @(posedge alu_clk); #1 alu_rst = 1'b0;
    settle(1);

    // T1: ADD 5+7
    rsp_log.delete(); grant_log.delete();
    drive(0, 4'd0, 32'd5, 32'd7);
    settle(4);
    chk("t1_count", rsp_log.size(), 1);
    chk("t1_owner", rsp_log[0].owner, 0);
    chk("t1_rslt", rsp_log[0].r, 32'd12);
    chk("t1_flags", rsp_log[0].f, 4'b0000);
    chk("t1_latency", rsp_log[0].cyc - grant_log[0].cyc, 3);

    // T2: SUB 3-3
    rsp_log.delete();
    drive(1, 4'd1, 32'd3, 32'd3);
    settle(4);
    chk("t2_owner", rsp_log[0].owner, 1);
    chk("t2_rslt", rsp_log[0].r, 32'd0);
    chk("t2_flags", rsp_log[0].f, 4'b0110);

    // Signed overflow passes V and N through
    rsp_log.delete();
    drive(0, 4'd0, 32'h7FFF_FFFF, 32'd1);
    settle(4);
    chk("ovf_rslt", rsp_log[0].r, 32'h8000_0000);
    chk("ovf_flags", rsp_log[0].f, 4'b1001);

    // T3: both requesters continuously valid after reset
    pulse_reset();
    rsp_log.delete(); grant_log.delete();
    fork
      stream(0, 3, 4'd3, 32'h0000_00F0, 32'h0000_000F);
      stream(1, 3, 4'd4, 32'h0000_00FF, 32'h0000_000F);
    join
    settle(4);
    chk("t3_grants", grant_log.size(), 6);
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant_order", grant_log[i].owner, i % 2);
      if (i > 0) chk("t3_grant_gap", grant_log[i].cyc - grant_log[i-1].cyc, 2);
    end
    chk("t3_rsps", rsp_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_rsp_order", rsp_log[i].owner, i % 2);
    chk("t3_or", rsp_log[0].r, 32'h0000_00FF);
    chk("t3_xor", rsp_log[1].r, 32'h0000_00F0);

    // T4: illegal opcode from req0
    drive(0, 4'hE, 32'd1, 32'd2);
    @(negedge alu_clk);
    chk("t4_valid", rsp0_valid, 1);
    chk("t4_err", rsp_err, 1);
    chk("t4_rslt", rsp_rslt, 32'd0);
    chk("t4_flags", rsp_flags, 4'b0100);
    chk("t4_ctrl", alu_ctrl, 4'hF);
    settle(2);

    // T5: reset while the op is in CAPTURE
    rsp_log.delete();
    drive(0, 4'd0, 32'h7FFF_FFFF, 32'd1);
    @(posedge alu_clk); #1 alu_rst = 1'b1;
    @(posedge alu_clk); #1 alu_rst = 1'b0;
    @(negedge alu_clk);
    chk("t5_busy", busy, 0);
    chk("t5_valid", rsp0_valid, 0);
    chk("t5_ctrl", alu_ctrl, 4'hF);
    chk("t5_rslt", rsp_rslt, 32'd0);
    settle(4);
    chk("t5_no_rsp", rsp_log.size(), 0);

    // T6: illegal op accepted in CAPTURE jumps ahead of the in-flight ADD
    rsp_log.delete();
    fork
      drive(0, 4'd0, 32'd10, 32'd20);
      drive(1, 4'hF, 32'd0, 32'd0);
    join
    settle(4);
    chk("t6_count", rsp_log.size(), 2);
    chk("t6_first_owner", rsp_log[0].owner, 1);
    chk("t6_first_err", rsp_log[0].err, 1);
    chk("t6_first_flags", rsp_log[0].f, 4'b0100);
    chk("t6_second_owner", rsp_log[1].owner, 0);
    chk("t6_second_err", rsp_log[1].err, 0);
    chk("t6_second_rslt", rsp_log[1].r, 32'd30);
    chk("t6_gap", rsp_log[1].cyc - rsp_log[0].cyc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #9000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
